// File: rtl/adder_pipe_n.sv
// Pipelined two's-complement adder/subtractor; the carry chain is cut into SEG-bit
// segments, one register stage per segment. Optional signed saturation: ADDER_PIPE_SAT_EN.
module adder_pipe_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   S,
    output logic             Ovf
);

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned LAST   = STAGES - 1;
    localparam int unsigned SW     = SEG + 1;

    // Per-stage word: low segments already summed, high segments still hold operand A.
    logic [WIDTH-1:0]  word_q [STAGES];
    logic [WIDTH-1:0]  bx_q   [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  word_in [STAGES];
    logic [WIDTH-1:0]  bx_in   [STAGES];
    logic [STAGES-1:0] cin;
    logic [STAGES-1:0] vin;
    logic [WIDTH-1:0]  word_d  [STAGES];
    logic [STAGES-1:0] cy_d;
    logic [SEG:0]      seg_sum;
    logic              ovf_d;
    logic              adv;

    assign adv       = !vld_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign S         = {cy_q[LAST], word_q[LAST]};
    assign Ovf       = ovf_q;

    // Stage inputs: stage 0 from the ports, stage k from the stage k-1 registers.
    always_comb begin
        word_in[0] = A;
        bx_in[0]   = Sub ? ~B : B;
        cin[0]     = Sub;
        vin[0]     = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            word_in[k] = word_q[k-1];
            bx_in[k]   = bx_q[k-1];
            cin[k]     = cy_q[k-1];
            vin[k]     = vld_q[k-1];
        end
    end

    // Segment adders; overflow and optional saturation resolved in the last stage.
    always_comb begin
        seg_sum = '0;
        cy_d    = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            seg_sum = SW'(word_in[k][k*SEG +: SEG]) + SW'(bx_in[k][k*SEG +: SEG]) + SW'(cin[k]);
            word_d[k] = word_in[k];
            word_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            cy_d[k] = seg_sum[SEG];
        end
        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        ovf_d = cy_d[LAST] ^ (word_in[LAST][WIDTH-1] ^ bx_in[LAST][WIDTH-1] ^ word_d[LAST][WIDTH-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (ovf_d) begin
            word_d[LAST] = {word_in[LAST][WIDTH-1], {(WIDTH-1){~word_in[LAST][WIDTH-1]}}};
        end
`endif
    end

    // Whole pipeline advances together; a stalled output freezes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                word_q[k] <= '0;
                bx_q[k]   <= '0;
            end
        end else if (adv) begin
            vld_q <= vin;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                word_q[k] <= word_d[k];
                bx_q[k]   <= bx_in[k];
            end
        end
    end

endmodule

// File: doc/adder_pipe_n.md
# adder_pipe_n

Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the fixed 8-bit ripple-carry adder. The carry chain is cut into SEG-bit segments, with one register stage per segment, so the clock rate is independent of WIDTH. It sits between operand producers and result consumers on valid/ready streams, accepts one operation per cycle, and stalls the whole pipeline on back-pressure.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of SEG.
- SEG, 8, bits resolved per pipeline stage; STAGES = WIDTH/SEG, minimum 1.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation present on A/B/Sub.
- in_ready  output  1  block can accept this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0: S = A+B; 1: S = A-B (computed as A + ~B + 1).
- out_valid  output  1  result present on S/Ovf.
- out_ready  input  1  consumer accepts this cycle.
- S  output  WIDTH+1  S[WIDTH-1:0] is the sum or difference; S[WIDTH] is the carry-out. For Sub=1, 1 means no borrow.
- Ovf  output  1  signed overflow of the WIDTH-bit result.

## Operation
- Stage k (0..STAGES-1) adds segment k of A and segment k of B'. B' is B, or ~B when Sub=1.
- The carry-in to stage k is the registered carry-out of stage k-1. Stage 0 takes Sub as its carry-in.
- Operands are skew-registered: segment j is carried unchanged until stage j consumes it. Completed sum segments are carried forward to the output.
- Each stage holds a valid bit. Stage registers load only when adv = !out_valid || out_ready.
- in_ready = adv, combinational. A transfer occurs when in_valid && in_ready.
- When adv=1 and no transfer occurs, a bubble (valid=0) enters stage 0. Bubbles are not compressed.
- Ovf = carry into MSB XOR carry out of MSB. It is computed in the last stage.
- Arithmetic is modulo 2^WIDTH; S[WIDTH] exposes the carry.
- For STAGES=1 the block is a single registered adder with the same handshake.

## Timing
- Reset (asynchronous): all stage valid bits 0, out_valid=0, S=0, Ovf=0, internal carries 0. in_ready=1 as soon as rst deasserts.
- Reset mid-operation: all in-flight operations are discarded. Nothing is emitted for them.
- Latency: for an operation transferred at edge t with no stalls, out_valid=1 with its S/Ovf in the cycle after edge t+STAGES-1, i.e. STAGES cycles.
- Throughput: one operation per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, in_ready=0 and every stage, including S/Ovf, holds unchanged. The output is stable until accepted.
- Results leave in input order.
- A simultaneous output accept and input transfer in one cycle is legal. Both occur, with no bubble inserted.
- out_valid falls only after an accepting edge with no valid operation in the last stage.

## Configuration
- ADDER_PIPE_SAT_EN undefined:
  - S[WIDTH-1:0] is the wrapped result.
  - Ovf is a flag only.
- ADDER_PIPE_SAT_EN defined:
  - Signed saturation is applied in the last stage.
  - On Ovf=1, S[WIDTH-1:0] = 0x7F..F if A is non-negative, or 0x80..0 if A is negative.
  - S[WIDTH] and Ovf still report the raw carry and overflow.
  - Latency is unchanged.

## Test plan
All scenarios use WIDTH=32, SEG=8 (STAGES=4) unless noted.
- Reset, then in_valid=1, A=0x0000_00FF, B=0x0000_0001, Sub=0, out_ready=1 -> 4 cycles later S=0x0_0000_0100, Ovf=0. This exercises carry across segment 0→1.
- A=0xFFFF_FFFF, B=0x1, Sub=0 -> S=0x1_0000_0000, Ovf=0. A=0x7FFF_FFFF, B=0x1 -> S=0x0_8000_0000, Ovf=1; with ADDER_PIPE_SAT_EN, S=0x0_7FFF_FFFF.
- Sub=1, A=5, B=7 -> S=0x0_FFFF_FFFE, S[32]=0 (borrow). A=7, B=5 -> S=0x1_0000_0002.
- Issue 6 back-to-back operations (A=i, B=i) with out_ready=1. Hold out_ready=0 for 3 cycles at the first result -> in_ready=0 and S frozen during the hold. Results 0,2,4,6,8,10 arrive in order, with none lost or duplicated.
- Issue 3 operations, assert rst for one cycle while they are in flight -> out_valid=0 and S=0 immediately. None of the 3 results ever appear.
- WIDTH=8, SEG=8 (STAGES=1): A=0x80, B=0x80, Sub=0 -> after 1 cycle S=0x100, Ovf=1.
